wbstage: RTL and testbench

WBSTAGE -- requirements
Module: wbstage

---
 rtl/wbstage.sv | 108 ++++++++++
 tb/tb_wbstage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wbstage.sv
// Write-back stage: two-entry skid buffer (OUT + SKID) in front of the
// register file, with a sticky halt latch that stops intake until flush/reset.
module wbstage #(
    parameter int DATA_W   = 32,
    parameter int IR_W     = 64,
    parameter int ADDR_LSB = 20,
    parameter int ADDR_W   = 4,
    parameter int BANK_W   = 4,
    parameter int WE_W     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              halt_i,
    input  logic [WE_W-1:0]   reg_write_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [BANK_W-1:0] bank_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              halt_o,
    output logic [WE_W-1:0]   reg_write_o,
    output logic [DATA_W-1:0] data_o,
    output logic [IR_W-1:0]   ir_o,
    output logic [ADDR_W-1:0] reg_write_addr_o,
    output logic [BANK_W-1:0] bank_o
);

    typedef struct packed {
        logic              halt;
        logic [WE_W-1:0]   we;
        logic [DATA_W-1:0] data;
        logic [IR_W-1:0]   ir;
        logic [BANK_W-1:0] bank;
    } ent_t;

    ent_t out_q, skid_q, out_n, skid_n, in_ent;
    logic out_vld, skid_vld, halt_lat, rdy_q;
    logic out_vld_n, skid_vld_n, halt_n;
    logic in_xfer, out_xfer;

    assign in_ent   = '{halt: halt_i, we: reg_write_i, data: data_i, ir: ir_i, bank: bank_i};
    assign in_xfer  = valid_i & rdy_q;
    assign out_xfer = out_vld & ready_i;

    // Next-state for both entries: drain first, then place the new entry in
    // whichever slot is free after the drain so ordering is preserved.
    always_comb begin
        out_n      = out_q;
        skid_n     = skid_q;
        out_vld_n  = out_vld;
        skid_vld_n = skid_vld;
        halt_n     = halt_lat | (in_xfer & halt_i);
        if (out_xfer) begin
            if (skid_vld) begin
                out_n      = skid_q;
                skid_vld_n = 1'b0;
            end else begin
                out_vld_n  = 1'b0;
            end
        end
        if (in_xfer) begin
            if (!out_vld_n) begin
                out_n     = in_ent;
                out_vld_n = 1'b1;
            end else begin
                skid_n     = in_ent;
                skid_vld_n = 1'b1;
            end
        end
    end

    // State update; flush only drops valid bits and the halt latch, payloads stay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            halt_lat <= 1'b0;
            rdy_q    <= 1'b1;
        end else if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            halt_lat <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            out_q    <= out_n;
            skid_q   <= skid_n;
            out_vld  <= out_vld_n;
            skid_vld <= skid_vld_n;
            halt_lat <= halt_n;
            rdy_q    <= ~skid_vld_n & ~halt_n;
        end
    end

    assign ready_o          = rdy_q;
    assign valid_o          = out_vld;
    assign halt_o           = out_q.halt & out_vld;
    assign reg_write_o      = out_vld ? out_q.we : '0;
    assign data_o           = out_q.data;
    assign ir_o             = out_q.ir;
    assign bank_o           = out_q.bank;
    assign reg_write_addr_o = out_q.ir[ADDR_LSB +: ADDR_W];

endmodule

// File: tb/tb_wbstage.sv
// Directed bench for wbstage: reset, streaming, backpressure, address
// extraction, halt, flush collision and mid-operation reset.
module tb_wbstage;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, halt_i, ready_i;
    logic [1:0]  reg_write_i;
    logic [31:0] data_i;
    logic [63:0] ir_i;
    logic [3:0]  bank_i;
    logic        ready_o, valid_o, halt_o;
    logic [1:0]  reg_write_o;
    logic [31:0] data_o;
    logic [63:0] ir_o;
    logic [3:0]  reg_write_addr_o, bank_o;

    int n_cmp = 0;
    int n_err = 0;

    wbstage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .halt_i(halt_i), .reg_write_i(reg_write_i),
        .data_i(data_i), .ir_i(ir_i), .bank_i(bank_i), .valid_o(valid_o),
        .ready_i(ready_i), .halt_o(halt_o), .reg_write_o(reg_write_o),
        .data_o(data_o), .ir_o(ir_o), .reg_write_addr_o(reg_write_addr_o),
        .bank_o(bank_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge and settle away from it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [1:0] we,
                         input logic [31:0] d, input logic [63:0] ir, input logic [3:0] b);
        valid_i = v; halt_i = h; reg_write_i = we; data_i = d; ir_i = ir; bank_i = b;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, valid_o, 0);
        chk({tag, ".ready"}, ready_o, 1);
        chk({tag, ".halt"},  halt_o, 0);
        chk({tag, ".we"},    reg_write_o, 0);
        chk({tag, ".data"},  data_o, 0);
        chk({tag, ".ir"},    ir_o, 0);
        chk({tag, ".addr"},  reg_write_addr_o, 0);
        chk({tag, ".bank"},  bank_o, 0);
    endtask

    initial begin
        rst_i = 1; flush_i = 0; ready_i = 0;
        drive(0, 0, 2'b00, 0, 0, 0);
        tick();
        rst_i = 0;
        chk_reset_vals("rst");

        // streaming
        ready_i = 1;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 2'b01, i, 0, 0);
            tick();
            chk($sformatf("stream%0d.data", i), data_o, i);
            chk($sformatf("stream%0d.valid", i), valid_o, 1);
            chk($sformatf("stream%0d.ready", i), ready_o, 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("stream.drain", valid_o, 0);

        // backpressure: A,B accepted, C stalls
        ready_i = 0;
        drive(1, 0, 2'b01, 32'hA, 0, 0);
        tick();
        chk("bp.A.data", data_o, 32'hA);
        chk("bp.A.ready", ready_o, 1);
        drive(1, 0, 2'b01, 32'hB, 0, 0);
        tick();
        chk("bp.B.hold", data_o, 32'hA);
        chk("bp.B.ready", ready_o, 0);
        drive(1, 0, 2'b01, 32'hC, 0, 0);
        tick();
        chk("bp.C.hold", data_o, 32'hA);
        chk("bp.C.ready", ready_o, 0);
        ready_i = 1;
        tick();
        chk("bp.rel.B", data_o, 32'hB);
        chk("bp.rel.ready", ready_o, 1);
        tick();
        chk("bp.rel.C", data_o, 32'hC);
        chk("bp.rel.Cvalid", valid_o, 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("bp.empty", valid_o, 0);

        // address extraction
        drive(1, 0, 2'b11, 32'h55, 64'h0000_0000_0050_0000, 4'h9);
        tick();
        chk("addr.addr", reg_write_addr_o, 4'h5);
        chk("addr.we", reg_write_o, 2'b11);
        chk("addr.ir", ir_o, 64'h0000_0000_0050_0000);
        chk("addr.bank", bank_o, 4'h9);
        drive(0, 0, 2'b11, 32'h66, 64'h0000_0000_00F0_0000, 4'h1);
        tick();
        chk("addr.gate_we", reg_write_o, 0);
        chk("addr.gate_valid", valid_o, 0);
        chk("addr.retain", data_o, 32'h55);

        // halt
        ready_i = 0;
        drive(1, 1, 2'b01, 32'h77, 0, 0);
        tick();
        chk("halt.halt_o", halt_o, 1);
        chk("halt.valid", valid_o, 1);
        chk("halt.ready", ready_o, 0);
        ready_i = 1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("halt.consumed", valid_o, 0);
        chk("halt.halt_gate", halt_o, 0);
        drive(1, 0, 2'b01, 32'h78, 0, 0);
        tick();
        chk("halt.sticky", ready_o, 0);
        chk("halt.noaccept", valid_o, 0);
        drive(0, 0, 0, 0, 0, 0);
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("halt.flush.valid", valid_o, 0);
        chk("halt.flush.ready", ready_o, 1);

        // flush collision
        ready_i = 0;
        drive(1, 0, 2'b10, 32'hA1, 0, 0);
        tick();
        drive(1, 0, 2'b10, 32'hA2, 0, 0);
        tick();
        chk("fc.full", ready_o, 0);
        flush_i = 1;
        drive(1, 0, 2'b11, 32'hEE, 0, 0);
        tick();
        flush_i = 0;
        chk("fc.valid", valid_o, 0);
        chk("fc.we", reg_write_o, 0);
        chk("fc.ready", ready_o, 1);
        chk("fc.retain", data_o, 32'hA1);
        drive(0, 0, 0, 0, 0, 0);
        ready_i = 1;
        tick();
        chk("fc.dropped", valid_o, 0);
        tick();
        chk("fc.dropped2", valid_o, 0);

        // reset mid-operation: both entries full, halt latched
        ready_i = 0;
        drive(1, 0, 2'b01, 32'hC1, 64'h0000_0000_0030_0000, 4'h3);
        tick();
        drive(1, 1, 2'b01, 32'hC2, 64'h0000_0000_0040_0000, 4'h4);
        tick();
        chk("mid.ready", ready_o, 0);
        chk("mid.data", data_o, 32'hC1);
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk_reset_vals("mid.rst");
        ready_i = 1;
        tick();
        chk("mid.no_skid", valid_o, 0);
        chk("mid.ready2", ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
